// File: rtl/da_pkg.sv
// da_pkg: shared sizes, state encoding and enable constants for the DA LUT path
package da_pkg;
    localparam int TAPS = 4;
    localparam int LUT_DEPTH = 1 << TAPS;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_LUT_W = DEF_COEF_W + 2;
    localparam logic ON = 1'b0;
    localparam logic OFF = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COLLECT = 2'd1,
        BUILD = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/da_subset_sum.sv
// da_subset_sum: masked signed sum of the four coefficients, sign-extended to LUT_W
module da_subset_sum #(
    parameter int COEF_W = da_pkg::DEF_COEF_W,
    parameter int LUT_W = COEF_W + 2
) (
    input logic signed [COEF_W-1:0] h [da_pkg::TAPS],
    input logic [da_pkg::TAPS-1:0] mask,
    output logic signed [LUT_W-1:0] sum
);
    always_comb begin
        sum = '0;
        for (int j = 0; j < da_pkg::TAPS; j++)
            sum = sum + (mask[j] ? {{(LUT_W-COEF_W){h[j][COEF_W-1]}}, h[j]} : {LUT_W{1'b0}});
    end
endmodule

// File: rtl/da_lut_builder.sv
// da_lut_builder: collects four coefficients and writes all 16 DA subset sums to the LUT
module da_lut_builder #(
    parameter int COEF_W = da_pkg::DEF_COEF_W,
    parameter int TAPS = da_pkg::TAPS,
    parameter int LUT_W = COEF_W + 2
) (
    input logic clk,
    input logic reset,
    input logic coef_valid,
    output logic coef_ready,
    input logic signed [COEF_W-1:0] coef_data,
    output logic lut_wr_valid,
    input logic lut_wr_ready,
    output logic [3:0] lut_addr,
    output logic signed [LUT_W-1:0] lut_data,
    output logic cload,
    output logic lut_ready
);
    if (TAPS != 4) begin : g_taps_check
        $error("da_lut_builder supports TAPS=4 only");
    end
    da_pkg::state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic signed [COEF_W-1:0] h_q [4];
    logic signed [COEF_W-1:0] h_d [4];
    logic [3:0] addr_q, addr_d;
    logic signed [LUT_W-1:0] sum, lut_data_q, lut_data_d;
    logic coef_ready_q, coef_ready_d;
    logic lut_wr_valid_q, lut_wr_valid_d;
    logic cload_q, cload_d;
    logic lut_ready_q, lut_ready_d;
    logic coef_fire, wr_fire;
    // Sum is taken from next-state h/addr so lut_data lands in the same register stage as lut_addr
    da_subset_sum #(.COEF_W(COEF_W), .LUT_W(LUT_W)) u_sum (
        .h(h_d),
        .mask(addr_d),
        .sum(sum)
    );
    always_comb begin
        coef_fire = coef_valid & coef_ready_q;
        wr_fire = lut_wr_valid_q & lut_wr_ready;
        state_d = state_q;
        cnt_d = cnt_q;
        h_d = h_q;
        addr_d = addr_q;
        case (state_q)
            da_pkg::IDLE, da_pkg::DONE: if (coef_fire) begin
                h_d[0] = coef_data;
                cnt_d = 2'd1;
                state_d = da_pkg::COLLECT;
            end
            da_pkg::COLLECT: if (coef_fire) begin
                h_d[cnt_q] = coef_data;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = da_pkg::BUILD;
                    addr_d = '0;
                end
            end
            da_pkg::BUILD: if (wr_fire) begin
                addr_d = addr_q + 4'd1;
                if (addr_q == 4'(da_pkg::LUT_DEPTH - 1)) state_d = da_pkg::DONE;
            end
            default: state_d = da_pkg::IDLE;
        endcase
        coef_ready_d = state_d != da_pkg::BUILD;
        lut_wr_valid_d = state_d == da_pkg::BUILD;
        cload_d = (state_d == da_pkg::COLLECT) || (state_d == da_pkg::BUILD);
        lut_ready_d = state_d == da_pkg::DONE;
        lut_data_d = (state_d == da_pkg::BUILD) ? sum : lut_data_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= da_pkg::IDLE;
            cnt_q <= '0;
            h_q <= '{default: '0};
            addr_q <= '0;
            lut_data_q <= '0;
            coef_ready_q <= 1'b1;
            lut_wr_valid_q <= 1'b0;
            cload_q <= 1'b0;
            lut_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            h_q <= h_d;
            addr_q <= addr_d;
            lut_data_q <= lut_data_d;
            coef_ready_q <= coef_ready_d;
            lut_wr_valid_q <= lut_wr_valid_d;
            cload_q <= cload_d;
            lut_ready_q <= lut_ready_d;
        end
    end
    assign coef_ready = coef_ready_q;
    assign lut_wr_valid = lut_wr_valid_q;
    assign lut_addr = addr_q;
    assign lut_data = lut_data_q;
    assign cload = cload_q;
    assign lut_ready = lut_ready_q;
endmodule

// File: tb/tb_da_lut_builder.sv
// tb_da_lut_builder: randomized coefficient/backpressure stimulus checked against a subset-sum model
module tb_da_lut_builder;
    localparam int COEF_W = 16;
    localparam int LUT_W = 18;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic coef_valid = 1'b0;
    logic coef_ready;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic lut_wr_valid;
    logic lut_wr_ready = 1'b1;
    logic [3:0] lut_addr;
    logic signed [LUT_W-1:0] lut_data;
    logic cload;
    logic lut_ready;
    int total = 0;
    int bad = 0;
    int mh [4];
    int exp_addr = 0;
    int got [16];
    int fired [$];
    bit bp = 1'b0;

    da_lut_builder #(.COEF_W(COEF_W), .TAPS(4), .LUT_W(LUT_W)) dut (
        .clk(clk),
        .reset(reset),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef_data(coef_data),
        .lut_wr_valid(lut_wr_valid),
        .lut_wr_ready(lut_wr_ready),
        .lut_addr(lut_addr),
        .lut_data(lut_data),
        .cload(cload),
        .lut_ready(lut_ready)
    );

    always #5 clk = ~clk;

    function automatic int subset(input int h [4], input int a);
        int s = 0;
        for (int j = 0; j < 4; j++) if (a[j]) s += h[j];
        return s;
    endfunction

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int n = 0;
        coef_valid = 1'b1;
        coef_data = COEF_W'(v);
        while (!coef_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("coef_accept_timeout", 0, 1);
        tick();
        coef_valid = 1'b0;
        coef_data = COEF_W'($urandom);
    endtask

    task automatic load(input int h [4], input int maxgap);
        mh = h;
        for (int i = 0; i < 4; i++) begin
            send(h[i]);
            repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!lut_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!lut_ready) chk("lut_ready_timeout", 0, 1);
    endtask

    task automatic check_log();
        chk("write_count", fired.size(), 16);
        for (int i = 0; i < fired.size() && i < 16; i++) chk("write_order", fired[i], i);
        fired = {};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        int h [4];
        int n;
        fork
            forever begin
                @(negedge clk);
                if (lut_wr_valid) begin
                    chk("wr_addr", lut_addr, exp_addr);
                    chk("wr_data", lut_data, subset(mh, exp_addr));
                    chk("coef_ready_in_build", coef_ready, 0);
                    if (lut_wr_ready && !reset) begin
                        fired.push_back(int'(lut_addr));
                        got[lut_addr] = int'(lut_data);
                        exp_addr++;
                    end
                end else begin
                    exp_addr = 0;
                end
            end
            forever begin
                tick();
                lut_wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        do_reset();
        chk("rst_coef_ready", coef_ready, 1);
        chk("rst_wr_valid", lut_wr_valid, 0);
        chk("rst_addr", lut_addr, 0);
        chk("rst_data", lut_data, 0);
        chk("rst_cload", cload, 0);
        chk("rst_lut_ready", lut_ready, 0);

        // Edges are counted with the h0 handshake edge as edge 1
        mh = '{3, -5, 7, 100};
        send(3);
        n = 1;
        chk("cload_after_h0", cload, 1);
        send(-5);
        send(7);
        send(100);
        n += 3;
        chk("first_req_valid", lut_wr_valid, 1);
        chk("first_req_addr", lut_addr, 0);
        while (!lut_ready && n < 100) begin
            chk("cload_during_load", cload, 1);
            tick();
            n++;
        end
        chk("ready_edge_from_h0", n, 20);
        chk("cload_falls_with_ready", cload, 0);
        chk("coef_ready_done", coef_ready, 1);
        check_log();
        chk("basic_e0", got[0], 0);
        chk("basic_e1", got[1], 3);
        chk("basic_e2", got[2], -5);
        chk("basic_e5", got[5], 10);
        chk("basic_e10", got[10], 95);
        chk("basic_e15", got[15], 105);

        h = '{-32768, -32768, -32768, -32768};
        load(h, 0);
        wait_ready();
        check_log();
        chk("extreme_e15", got[15], -131072);
        chk("extreme_e7", got[7], -98304);

        // Backpressure and gapped coefficients, with coef_valid held through BUILD
        for (int r = 0; r < 6; r++) begin
            bp = 1'b1;
            for (int i = 0; i < 4; i++) h[i] = $signed(16'($urandom));
            load(h, 3);
            coef_valid = 1'b1;
            coef_data = COEF_W'($urandom);
            repeat (4) tick();
            coef_valid = 1'b0;
            wait_ready();
            check_log();
        end
        bp = 1'b0;

        h = '{11, -22, 33, -44};
        load(h, 0);
        n = 0;
        while (!(lut_wr_valid && lut_addr == 4'd7) && n < 100) begin
            tick();
            n++;
        end
        chk("reached_addr7", lut_addr, 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_wr_valid", lut_wr_valid, 0);
        chk("abort_cload", cload, 0);
        chk("abort_lut_ready", lut_ready, 0);
        chk("abort_coef_ready", coef_ready, 1);
        repeat (3) tick();
        chk("abort_stays_idle", lut_wr_valid, 0);
        fired = {};
        bp = 1'b1;
        for (int i = 0; i < 4; i++) h[i] = $signed(16'($urandom));
        load(h, 2);
        wait_ready();
        check_log();
        bp = 1'b0;

        chk("ready_before_rebuild", lut_ready, 1);
        h = '{1, 2, 4, 8};
        mh = h;
        send(1);
        chk("rebuild_ready_drop", lut_ready, 0);
        chk("rebuild_cload", cload, 1);
        send(2);
        send(4);
        send(8);
        wait_ready();
        check_log();
        for (int k = 0; k < 16; k++) chk("rebuild_entry", got[k], k);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
